arm_mem_loader: RTL and testbench

ARM_MEM_LOADER -- requirements
Module: arm_mem_loader

---
 rtl/arm_mem_loader_if.sv | 24 ++
 rtl/arm_mem_loader.sv | 184 ++++++++++++++++++
 tb/tb_arm_mem_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_loader_if.sv
// arm_mem_loader_if: byte-stream input and data-memory download port.
// The loader uses the slave modport; the stream source uses master.
interface arm_mem_loader_if #(
  parameter int unsigned width = 32
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             download_data_we;
  logic [width-1:0] download_data_addr;
  logic [width-1:0] download_data;

  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  download_data_we, download_data_addr, download_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output download_data_we, download_data_addr, download_data
  );
endinterface

// File: rtl/arm_mem_loader.sv
// arm_mem_loader: loads a little-endian byte stream into the core's data memory.
// Define ARM_MEM_LOADER_CHECKSUM_EN to verify a trailing 32-bit word sum.
module arm_mem_loader #(
  parameter int unsigned      width     = 32,
  parameter logic [width-1:0] base_addr = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  arm_mem_loader_if.slave bus,
  output logic            core_reset,
  output logic            busy,
  output logic            done,
  output logic            error
);

`ifdef ARM_MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_WR, S_CHK, S_DONE
  } state_t;
  localparam state_t S_END = S_CHK;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_WR, S_DONE
  } state_t;
  localparam state_t S_END = S_DONE;
`endif

  state_t           state_q, state_d;
  logic [1:0]       byte_q, byte_d;
  logic [31:0]      sh_q, sh_d;
  logic [31:0]      n_q, n_d;
  logic [31:0]      k_q, k_d;
  logic             we_q, we_d;
  logic [width-1:0] addr_q, addr_d;
  logic [width-1:0] data_q, data_d;
  logic             rdy_q, rdy_d;
  logic             crst_q, crst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
  logic [31:0]      sum_q, sum_d;
  logic             err_q, err_d;
`endif

  logic        fire;
  logic [31:0] asm_w;

  // ready is registered, so it already reflects the current state
  assign fire  = bus.in_valid & rdy_q;
  assign asm_w = {bus.in_data, sh_q[31:8]};

  // next-state and next-output logic
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    n_d     = n_q;
    k_d     = k_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_HDR;
          byte_d  = 2'd0;
          k_d     = 32'd0;
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
          sum_d   = 32'd0;
          err_d   = 1'b0;
`endif
        end
      end
      S_HDR: begin
        if (fire) begin
          sh_d   = asm_w;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            n_d     = asm_w;
            state_d = (asm_w == 32'd0) ? S_END : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (fire) begin
          sh_d   = asm_w;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            state_d = S_WR;
            we_d    = 1'b1;
            addr_d  = base_addr + (width'(k_q) << 2);
            data_d  = width'(asm_w);
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
            sum_d   = sum_q + asm_w;
`endif
          end
        end
      end
      S_WR: begin
        k_d     = k_q + 32'd1;
        state_d = (k_q + 32'd1 == n_q) ? S_END : S_LOAD;
      end
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (fire) begin
          sh_d   = asm_w;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            err_d   = (asm_w != sum_q);
            state_d = S_DONE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    rdy_d  = (state_d == S_HDR) || (state_d == S_LOAD);
    busy_d = rdy_d || (state_d == S_WR);
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
    rdy_d  = rdy_d || (state_d == S_CHK);
    busy_d = busy_d || (state_d == S_CHK);
`endif
    done_d = (state_d == S_DONE);
    crst_d = !done_d;
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      byte_q  <= 2'd0;
      sh_q    <= 32'd0;
      n_q     <= 32'd0;
      k_q     <= 32'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      crst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
      sum_q   <= 32'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      n_q     <= n_d;
      k_q     <= k_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready           = rdy_q;
  assign bus.download_data_we   = we_q;
  assign bus.download_data_addr = addr_q;
  assign bus.download_data      = data_q;
  assign core_reset             = crst_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
  assign error                  = err_q;
`else
  assign error                  = 1'b0;
`endif

endmodule

// File: tb/tb_arm_mem_loader.sv
// tb_arm_mem_loader: directed test of arm_mem_loader.
// Two instances (base 0x0 and 0x100) share one byte stream.
module tb_arm_mem_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       cr0, busy0, done0, err0;
  logic       cr1, busy1, done1, err1;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int wr_n0 = 0;
  int wr_n1 = 0;

  logic [31:0] wv [8];
  logic [31:0] a0 [64];
  logic [31:0] d0 [64];
  logic [31:0] a1 [64];
  int          c0 [64];

  arm_mem_loader_if #(.width(32)) if0 ();
  arm_mem_loader_if #(.width(32)) if1 ();

  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;

  arm_mem_loader #(.width(32), .base_addr(32'h0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .bus(if0.slave),
    .core_reset(cr0), .busy(busy0), .done(done0), .error(err0)
  );

  arm_mem_loader #(.width(32), .base_addr(32'h100)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .bus(if1.slave),
    .core_reset(cr1), .busy(busy1), .done(done1), .error(err1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if0.download_data_we) begin
      if (wr_n0 < 64) begin
        a0[wr_n0] = if0.download_data_addr;
        d0[wr_n0] = if0.download_data;
        c0[wr_n0] = cyc;
      end
      wr_n0 = wr_n0 + 1;
    end
    if (if1.download_data_we) begin
      if (wr_n1 < 64) a1[wr_n1] = if1.download_data_addr;
      wr_n1 = wr_n1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!if0.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("rdy_wait", {31'd0, if0.in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int t = 0;
    while (!done0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, {31'd0, done0}, 32'd1);
    check({tag, "_core_reset"}, {31'd0, cr0}, 32'd0);
    check({tag, "_error"}, {31'd0, err0}, {31'd0, exp_err});
  endtask

  task automatic run_session(input string tag, input int n, input bit gap,
                             input logic [31:0] cs, input logic exp_err);
    pulse_start();
    check({tag, "_hdr_core_reset"}, {31'd0, cr0}, 32'd1);
    check({tag, "_hdr_busy"}, {31'd0, busy0}, 32'd1);
    send_word(n, gap);
    for (int i = 0; i < n; i++) send_word(wv[i], gap);
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
    send_word(cs, gap);
`else
    if (cs != 32'd0) in_data = 8'h00;
`endif
    wait_done(tag, exp_err);
  endtask

  task automatic check_writes(input string tag, input int n,
                              input int b0, input int b1);
    check({tag, "_wr_count0"}, wr_n0 - b0, n);
    check({tag, "_wr_count1"}, wr_n1 - b1, n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr0_%0d", tag, i), a0[b0+i], 32'(4 * i));
      check($sformatf("%s_addr1_%0d", tag, i), a1[b1+i],
            32'h100 + 32'(4 * i));
      check($sformatf("%s_data_%0d", tag, i), d0[b0+i], wv[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int b0, b1;
    logic [31:0] s;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, if0.in_ready}, 32'd0);
    check("rst_we", {31'd0, if0.download_data_we}, 32'd0);
    check("rst_addr", if0.download_data_addr, 32'd0);
    check("rst_data", if0.download_data, 32'd0);
    check("rst_core_reset", {31'd0, cr0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_error", {31'd0, err0}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'd0, if0.in_ready}, 32'd0);

    // two words, valid held high
    wv[0] = 32'h12345678;
    wv[1] = 32'hDEADBEEF;
    s  = wv[0] + wv[1];
    b0 = wr_n0;
    b1 = wr_n1;
    run_session("t1", 2, 1'b0, s, 1'b0);
    check_writes("t1", 2, b0, b1);
    check("t1_spacing", c0[b0+1] - c0[b0], 32'd5);
    check("t1_addr_hold", if0.download_data_addr, 32'h4);
    check("t1_data_hold", if0.download_data, 32'hDEADBEEF);
    check("t1_we_idle", {31'd0, if0.download_data_we}, 32'd0);

    // restart from DONE, three words, valid toggled
    wv[0] = 32'hCAFE0001;
    wv[1] = 32'h0BADF00D;
    wv[2] = 32'h00000003;
    s  = wv[0] + wv[1] + wv[2];
    b0 = wr_n0;
    b1 = wr_n1;
    run_session("t2", 3, 1'b1, s, 1'b0);
    check_writes("t2", 3, b0, b1);

    // start pulsed mid-word is ignored
    wv[0] = 32'h11223344;
    b0 = wr_n0;
    b1 = wr_n1;
    pulse_start();
    send_word(32'd1, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    pulse_start();
    check("t3_busy", {31'd0, busy0}, 32'd1);
    check("t3_core_reset", {31'd0, cr0}, 32'd1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h11, 1'b0);
`ifdef ARM_MEM_LOADER_CHECKSUM_EN
    send_word(32'h11223344, 1'b0);
`endif
    wait_done("t3", 1'b0);
    check_writes("t3", 1, b0, b1);

    // reset after two bytes of the first word
    b0 = wr_n0;
    pulse_start();
    send_word(32'd2, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t4_core_reset", {31'd0, cr0}, 32'd1);
    check("t4_busy", {31'd0, busy0}, 32'd0);
    check("t4_in_ready", {31'd0, if0.in_ready}, 32'd0);
    check("t4_no_write", wr_n0 - b0, 32'd0);
    wv[0] = 32'h55667788;
    b0 = wr_n0;
    b1 = wr_n1;
    run_session("t4b", 1, 1'b0, 32'h55667788, 1'b0);
    check_writes("t4b", 1, b0, b1);

    // empty image
    b0 = wr_n0;
    b1 = wr_n1;
    run_session("t5", 0, 1'b0, 32'd0, 1'b0);
    check_writes("t5", 0, b0, b1);

`ifdef ARM_MEM_LOADER_CHECKSUM_EN
    wv[0] = 32'd1;
    wv[1] = 32'd2;
    run_session("t6_ok", 2, 1'b0, 32'd3, 1'b0);
    run_session("t6_bad", 2, 1'b0, 32'd4, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
